// File: rtl/clkdiv_multi.sv
// clkdiv_multi: multi-channel fractional clock-enable generator (freq strobes per fref clocks).
// Optional macro CLKDIV_SYNC_EN enables the common `sync` phase-align strobe.
module clkdiv_multi #(
   parameter int unsigned CHANNELS = 3,
   parameter int unsigned WIDTH    = 16
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [CHANNELS-1:0]       active,
   input  logic [CHANNELS-1:0]       load,
   input  logic [CHANNELS*WIDTH-1:0] freq,
   input  logic [CHANNELS*WIDTH-1:0] fref,
   input  logic                      sync,
   output logic [CHANNELS-1:0]       hold,
   output logic [CHANNELS-1:0]       busy
);

   localparam int unsigned ACC_W = WIDTH + 1;

`ifdef CLKDIV_SYNC_EN
   logic sync_c;
   assign sync_c = sync;
`else
   // Sync disabled: the input is tied off and its clearing logic folds away.
   logic unused_sync;
   logic sync_c;
   assign unused_sync = sync;
   assign sync_c      = 1'b0;
`endif

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] f_q, f_d;
      logic [WIDTH-1:0] r_q, r_d;
      logic [ACC_W-1:0] acc_q, acc_d;
      logic [ACC_W-1:0] n_c;
      logic             hold_q, hold_d;
      logic             busy_q, busy_d;

      // Sum is one bit wider than the operands, so it never wraps.
      assign n_c = acc_q + ACC_W'(f_q);

      // Priority: load, then sync, then stepping; inactive freezes phase.
      always_comb begin
         f_d    = f_q;
         r_d    = r_q;
         acc_d  = acc_q;
         hold_d = 1'b0;
         busy_d = active[i] & (r_q != '0) & (f_q != '0);
         if (load[i]) begin
            f_d   = freq[i*WIDTH +: WIDTH];
            r_d   = fref[i*WIDTH +: WIDTH];
            acc_d = '0;
         end else if (sync_c) begin
            acc_d = '0;
         end else if (active[i]) begin
            if (r_q == '0) begin
               acc_d = '0;
            end else if (f_q >= r_q) begin
               acc_d  = '0;
               hold_d = 1'b1;
            end else if (n_c >= ACC_W'(r_q)) begin
               acc_d  = n_c - ACC_W'(r_q);
               hold_d = 1'b1;
            end else begin
               acc_d = n_c;
            end
         end
      end

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            f_q    <= '0;
            r_q    <= '0;
            acc_q  <= '0;
            hold_q <= 1'b0;
            busy_q <= 1'b0;
         end else begin
            f_q    <= f_d;
            r_q    <= r_d;
            acc_q  <= acc_d;
            hold_q <= hold_d;
            busy_q <= busy_d;
         end
      end

      assign hold[i] = hold_q;
      assign busy[i] = busy_q;
   end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi: vector table, corner-case sequences and
// randomized traffic against an arithmetic reference model.
module tb_clkdiv_multi;

   localparam int unsigned CH = 3;
   localparam int unsigned W  = 16;
`ifdef CLKDIV_SYNC_EN
   localparam bit SYNC_EN = 1'b1;
`else
   localparam bit SYNC_EN = 1'b0;
`endif

   logic            clock;
   logic            reset_n;
   logic [CH-1:0]   active;
   logic [CH-1:0]   load;
   logic [CH*W-1:0] freq;
   logic [CH*W-1:0] fref;
   logic            sync;
   logic [CH-1:0]   hold;
   logic [CH-1:0]   busy;

   clkdiv_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .active  (active),
      .load    (load),
      .freq    (freq),
      .fref    (fref),
      .sync    (sync),
      .hold    (hold),
      .busy    (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // Reference model: ratio f/r per channel, phase as a plain integer.
   longint unsigned m_f  [CH];
   longint unsigned m_r  [CH];
   longint unsigned m_ph [CH];
   logic [CH-1:0]   m_hold;
   logic [CH-1:0]   m_busy;

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_f[c] = 0; m_r[c] = 0; m_ph[c] = 0;
      end
      m_hold = '0;
      m_busy = '0;
   endtask

   task automatic model_step(input logic [CH-1:0] a, input logic [CH-1:0] l,
                             input logic [CH*W-1:0] fq, input logic [CH*W-1:0] fr,
                             input logic s);
      for (int c = 0; c < CH; c++) begin
         m_busy[c] = a[c] && (m_r[c] != 0) && (m_f[c] != 0);
         m_hold[c] = 1'b0;
         if (l[c]) begin
            m_f[c]  = longint'(fq[c*W +: W]);
            m_r[c]  = longint'(fr[c*W +: W]);
            m_ph[c] = 0;
         end else if (SYNC_EN && s) begin
            m_ph[c] = 0;
         end else if (a[c]) begin
            if (m_r[c] == 0) begin
               m_ph[c] = 0;
            end else if (m_f[c] >= m_r[c]) begin
               m_ph[c]   = 0;
               m_hold[c] = 1'b1;
            end else begin
               m_ph[c] = m_ph[c] + m_f[c];
               if (m_ph[c] >= m_r[c]) begin
                  m_ph[c]   = m_ph[c] - m_r[c];
                  m_hold[c] = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [CH*W-1:0] pk(input int v0, input int v1, input int v2);
      return {16'(v2), 16'(v1), 16'(v0)};
   endfunction

   // One clock: drive inputs, advance model at the edge, sample 1 unit later.
   task automatic cycle(input logic [CH-1:0] a, input logic [CH-1:0] l,
                        input logic [CH*W-1:0] fq, input logic [CH*W-1:0] fr,
                        input logic s, input bit chk);
      active = a; load = l; freq = fq; fref = fr; sync = s;
      @(posedge clock);
      model_step(a, l, fq, fr, s);
      #1;
      if (chk) begin
         check("model hold", 32'(hold), 32'(m_hold));
         check("model busy", 32'(busy), 32'(m_busy));
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      @(posedge clock);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic [CH-1:0] act;
      logic [CH-1:0] ld;
      int            f1, r1, f2, r2;
      logic [CH-1:0] exp_hold;
      logic [CH-1:0] exp_busy;
   } vec_t;

   vec_t vecs[11];

   initial begin
      #20000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cnt, gap, first, steps, wide, diffs;
      logic prev;

      // ch1: 1/2 toggles, ch2: 5/3 clamps; then zero ratios silence both.
      vecs[0]  = '{3'b110, 3'b110, 1, 2, 5, 3, 3'b000, 3'b000};
      vecs[1]  = '{3'b110, 3'b000, 0, 0, 0, 0, 3'b100, 3'b110};
      vecs[2]  = '{3'b110, 3'b000, 0, 0, 0, 0, 3'b110, 3'b110};
      vecs[3]  = '{3'b110, 3'b000, 0, 0, 0, 0, 3'b100, 3'b110};
      vecs[4]  = '{3'b110, 3'b000, 0, 0, 0, 0, 3'b110, 3'b110};
      vecs[5]  = '{3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000};
      vecs[6]  = '{3'b110, 3'b000, 0, 0, 0, 0, 3'b100, 3'b110};
      vecs[7]  = '{3'b110, 3'b110, 0, 0, 0, 0, 3'b000, 3'b110};
      vecs[8]  = '{3'b110, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000};
      vecs[9]  = '{3'b110, 3'b100, 0, 0, 7, 0, 3'b000, 3'b000};
      vecs[10] = '{3'b110, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000};

      reset_n = 1'b0; active = '0; load = '0; freq = '0; fref = '0; sync = 1'b0;
      model_reset();
      @(posedge clock);
      #1;
      check("reset hold", 32'(hold), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;

      // No strobes before the first load even when active.
      for (int k = 0; k < 5; k++) cycle(3'b111, '0, '0, '0, 1'b0, 1'b1);

      for (int i = 0; i < 11; i++) begin
         cycle(vecs[i].act, vecs[i].ld, pk(0, vecs[i].f1, vecs[i].f2),
               pk(0, vecs[i].r1, vecs[i].r2), 1'b0, 1'b1);
         check($sformatf("vec%0d hold", i), 32'(hold), 32'(vecs[i].exp_hold));
         check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      end

      // ch0 43/250 over 2500 active cycles with a 100-cycle inactive gap.
      do_reset();
      cycle(3'b001, 3'b001, pk(43, 0, 0), pk(250, 0, 0), 1'b0, 1'b1);
      cnt = 0; gap = 0; first = -1; steps = 0; wide = 0; prev = 1'b0;
      for (int k = 0; k < 2600; k++) begin
         logic a0;
         a0 = !(k >= 1200 && k < 1300);
         cycle({2'b00, a0}, '0, '0, '0, 1'b0, 1'b1);
         if (a0) steps++;
         if (hold[0]) begin
            cnt++;
            if (!a0) gap++;
            if (first < 0) first = steps;
            if (prev) wide++;
         end
         prev = hold[0];
      end
      check("rate 43/250 pulses", 32'(cnt), 32'd430);
      check("gap pulses", 32'(gap), 32'd0);
      check("first pulse step", 32'(first), 32'd6);
      check("pulse width", 32'(wide), 32'd0);
      check("busy0 running", 32'(busy[0]), 32'd1);

      // Reload on the edge where a strobe was due: suppressed, count restarts.
      cycle(3'b001, 3'b001, pk(43, 0, 0), pk(250, 0, 0), 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) cycle(3'b001, '0, '0, '0, 1'b0, 1'b1);
      cycle(3'b001, 3'b001, pk(43, 0, 0), pk(250, 0, 0), 1'b0, 1'b1);
      check("load over due strobe", 32'(hold[0]), 32'd0);
      first = -1;
      for (int k = 1; k <= 8; k++) begin
         cycle(3'b001, '0, '0, '0, 1'b0, 1'b1);
         if (hold[0] && first < 0) first = k;
      end
      check("first after reload", 32'(first), 32'd6);

      // Reset mid-run: immediate silence, and silence until reloaded.
      cycle(3'b001, 3'b001, pk(125, 0, 0), pk(250, 0, 0), 1'b0, 1'b1);
      for (int k = 0; k < 9; k++) cycle(3'b001, '0, '0, '0, 1'b0, 1'b1);
      check("pre-reset busy0", 32'(busy[0]), 32'd1);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check("async reset hold", 32'(hold), 32'd0);
      check("async reset busy", 32'(busy), 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 50; k++) begin
         cycle(3'b111, '0, '0, '0, 1'b0, 1'b1);
         if (hold != '0 || busy != '0) cnt++;
      end
      check("silent after reset", 32'(cnt), 32'd0);

      // Two channels at 3/7 loaded 4 cycles apart, then sync.
      cycle(3'b011, 3'b001, pk(3, 0, 0), pk(7, 0, 0), 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) cycle(3'b011, '0, '0, '0, 1'b0, 1'b1);
      cycle(3'b011, 3'b010, pk(0, 3, 0), pk(0, 7, 0), 1'b0, 1'b1);
      for (int k = 0; k < 10; k++) cycle(3'b011, '0, '0, '0, 1'b0, 1'b1);
      cycle(3'b011, '0, '0, '0, 1'b1, 1'b1);
      diffs = 0;
      for (int k = 0; k < 30; k++) begin
         cycle(3'b011, '0, '0, '0, 1'b0, 1'b1);
         if (hold[0] != hold[1]) diffs++;
      end
      if (SYNC_EN) check("sync lockstep diffs", 32'(diffs), 32'd0);
      else         check("unsynced offset", 32'(diffs != 0), 32'd1);

      // Sync coincident with a load of ch1: new ratio 2/5 from phase 0.
      cycle(3'b011, 3'b010, pk(0, 2, 0), pk(0, 5, 0), 1'b1, 1'b1);
      check("sync+load hold1", 32'(hold[1]), 32'd0);
      first = -1;
      for (int k = 1; k <= 5; k++) begin
         cycle(3'b011, '0, '0, '0, 1'b0, 1'b1);
         if (hold[1] && first < 0) first = k;
      end
      check("sync+load first", 32'(first), 32'd3);

      // Randomized traffic against the model.
      cycle(3'b111, 3'b111, pk(3, 1, 9), pk(10, 4, 9), 1'b0, 1'b1);
      for (int k = 0; k < 3000; k++) begin
         logic [CH-1:0]   a, l;
         logic [CH*W-1:0] fq, fr;
         logic            s;
         a = 3'($urandom_range(0, 7)) | 3'($urandom_range(0, 7));
         l = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
         for (int c = 0; c < CH; c++) begin
            fq[c*W +: W] = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 12)) : 16'($urandom);
            fr[c*W +: W] = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 12)) : 16'($urandom);
         end
         s = ($urandom_range(0, 39) == 0);
         cycle(a, l, fq, fr, s, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
